// File: rtl/multi_edge_pulse.sv
// multi_edge_pulse: per-channel stability filter, mode-selected edge detect, fixed-width non-retriggerable tick
module multi_edge_pulse #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 1,
  parameter int PULSE_CYCLES  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   sig,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   tick,
  output logic [CHANNELS-1:0]   overrun,
  output logic [CHANNELS-1:0]   level
);
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int PW = $clog2(PULSE_CYCLES) + 1;
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES - 1);
  localparam logic [PW-1:0] PMAX = PW'(PULSE_CYCLES - 1);
  typedef enum logic {IDLE, PULSE} state_t;
  for (genvar c = 0; c < CHANNELS; c++) begin : ch
    state_t state, state_nx;
    logic [SW-1:0] scnt;
    logic [PW-1:0] pcnt, pcnt_nx;
    logic lvl, ovr, acc, qual;
    always_ff @(posedge clock) begin
      if (reset) begin
        state <= IDLE;
        scnt  <= '0;
        pcnt  <= '0;
        lvl   <= 1'b0;
        ovr   <= 1'b0;
      end else begin
        state <= state_nx;
        pcnt  <= pcnt_nx;
        ovr   <= qual && state == PULSE;
        lvl   <= acc ? sig[c] : lvl;
        scnt  <= (sig[c] == lvl || acc) ? '0 : scnt + SW'(1);
      end
    end
    // bit 2c enables rising edges, bit 2c+1 falling edges
    always_comb begin
      acc      = sig[c] != lvl && scnt == SMAX;
      qual     = acc && (sig[c] ? mode[2*c] : mode[2*c+1]);
      state_nx = state == IDLE ? (qual ? PULSE : IDLE) : (pcnt == '0 ? IDLE : PULSE);
      pcnt_nx  = state == IDLE ? PMAX : pcnt - PW'(1);
    end
    assign tick[c]    = state == PULSE;
    assign overrun[c] = ovr;
    assign level[c]   = lvl;
  end
endmodule

// File: tb/tb_multi_edge_pulse.sv
// tb_multi_edge_pulse: two configurations checked every cycle against an event-level model plus literal pins
module tb_multi_edge_pulse;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic       rst [2];
  logic [3:0] sig [2];
  logic [7:0] mode[2];
  logic [3:0] tk[2], ov[2], lv[2];
  multi_edge_pulse u0 (
    .clock(clock), .reset(rst[0]), .sig(sig[0]), .mode(mode[0]),
    .tick(tk[0]), .overrun(ov[0]), .level(lv[0])
  );
  multi_edge_pulse #(.STABLE_CYCLES(3), .PULSE_CYCLES(4)) u1 (
    .clock(clock), .reset(rst[1]), .sig(sig[1]), .mode(mode[1]),
    .tick(tk[1]), .overrun(ov[1]), .level(lv[1])
  );
  int sc[2] = '{1, 3};
  int pc[2] = '{1, 4};
  int run[2][4], rem[2][4];
  bit mlv[2][4], mov[2][4];
  bit busy, acc, q, live = 0;
  int checks = 0, passed = 0;
  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask
  // model: samples-differing run length, remaining tick cycles
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++)
        if (rst[d]) begin
          run[d][c] = 0; rem[d][c] = 0; mlv[d][c] = 0; mov[d][c] = 0;
        end else begin
          busy = rem[d][c] > 0;
          acc  = 0;
          if (sig[d][c] != mlv[d][c]) begin
            run[d][c]++;
            if (run[d][c] == sc[d]) begin
              acc = 1; mlv[d][c] = sig[d][c]; run[d][c] = 0;
            end
          end else run[d][c] = 0;
          q = acc && (sig[d][c] ? mode[d][2*c] : mode[d][2*c+1]);
          mov[d][c] = q && busy;
          if (busy) rem[d][c]--;
          else if (q) rem[d][c] = pc[d];
        end
    live = 1;
  end
  always @(negedge clock) if (live)
    for (int d = 0; d < 2; d++) begin
      logic [3:0] et, eo, el;
      for (int c = 0; c < 4; c++) begin
        et[c] = rem[d][c] > 0; eo[c] = mov[d][c]; el[c] = mlv[d][c];
      end
      check($sformatf("dut%0d tick", d), tk[d], et);
      check($sformatf("dut%0d overrun", d), ov[d], eo);
      check($sformatf("dut%0d level", d), lv[d], el);
    end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  initial begin
    rst = '{1'b1, 1'b1}; sig = '{4'h0, 4'h0}; mode = '{8'h00, 8'h00};
    cyc(2);
    rst = '{1'b0, 1'b0};
    // defaults: single rising tick on ch0
    mode[0] = 8'h01;
    cyc(1);
    sig[0] = 4'b0001;
    cyc(1);
    check("a tick", tk[0], 4'b0001);
    check("a level", lv[0], 4'b0001);
    cyc(2);
    check("a tick end", tk[0], 4'b0000);
    sig[0] = 4'b0000;
    cyc(1);
    check("a fall level", lv[0], 4'b0000);
    check("a fall tick", tk[0], 4'b0000);
    // ch1 falling-only, ch2 rising-only
    mode[0] = 8'b00_01_10_00;
    sig[0] = 4'b0110;
    cyc(1);
    check("d rise", tk[0], 4'b0100);
    cyc(1);
    sig[0] = 4'b0000;
    cyc(1);
    check("d fall", tk[0], 4'b0010);
    sig[0] = 4'b1000;
    cyc(1);
    check("d mode00 level", lv[0], 4'b1000);
    check("d mode00 tick", tk[0], 4'b0000);
    mode[0] = 8'b01_01_10_00;
    cyc(2);
    check("d mode change", tk[0], 4'b0000);
    // STABLE_CYCLES=3 glitch then real edge
    mode[1] = 8'h01;
    sig[1] = 4'b0001;
    cyc(2);
    sig[1] = 4'b0000;
    cyc(3);
    check("b glitch level", lv[1], 4'b0000);
    sig[1] = 4'b0001;
    cyc(2);
    check("b early tick", tk[1], 4'b0000);
    cyc(1);
    check("b tick", tk[1], 4'b0001);
    check("b level", lv[1], 4'b0001);
    cyc(5);
    // PULSE_CYCLES=4, both edges on ch1: overrun then two separate pulses
    mode[1] = 8'b0000_1101;
    sig[1] = 4'b0011;
    cyc(3);
    check("c tick", tk[1], 4'b0010);
    sig[1] = 4'b0001;
    cyc(3);
    check("c overrun", ov[1], 4'b0010);
    check("c tick held", tk[1], 4'b0010);
    cyc(8);
    sig[1] = 4'b0011;
    cyc(6);
    sig[1] = 4'b0001;
    cyc(10);
    // reset mid-pulse
    mode[1] = 8'h01;
    sig[1] = 4'b0000;
    cyc(4);
    sig[1] = 4'b0001;
    cyc(3);
    check("r pulse", tk[1], 4'b0001);
    cyc(1);
    rst[1] = 1'b1;
    cyc(1);
    check("r tick", tk[1], 4'b0000);
    check("r overrun", ov[1], 4'b0000);
    check("r level", lv[1], 4'b0000);
    rst[1] = 1'b0;
    // input held high through reset release
    rst[0] = 1'b1; mode[0] = 8'h01; sig[0] = 4'b0001;
    cyc(2);
    check("h reset tick", tk[0], 4'b0000);
    rst[0] = 1'b0;
    cyc(1);
    check("h tick", tk[0], 4'b0001);
    cyc(6);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
